// File: rtl/wb_bus_arbiter.sv
// Two-master (fetch I / data D) to one-slave classic Wishbone arbiter with cycle-long grant
// locking, fixed-priority or round-robin tie break, and a strobe watchdog that errors out hung cycles.
module wb_bus_arbiter #(
  parameter bit ROUND_ROBIN = 1'b0,
  parameter int TIMEOUT     = 255,
  parameter int TO_W        = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        iwbs_cyc_i,
  input  logic        iwbs_stb_i,
  input  logic [31:0] iwbs_addr_i,
  output logic        iwbs_ack_o,
  output logic        iwbs_err_o,
  output logic [31:0] iwbs_dat_o,
  input  logic        dwbs_cyc_i,
  input  logic        dwbs_stb_i,
  input  logic        dwbs_we_i,
  input  logic [3:0]  dwbs_sel_i,
  input  logic [31:0] dwbs_addr_i,
  input  logic [31:0] dwbs_dat_i,
  output logic        dwbs_ack_o,
  output logic        dwbs_err_o,
  output logic [31:0] dwbs_dat_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_addr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic [31:0] wbm_dat_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t          r_state, w_next;
  logic            r_abort, w_abort_nxt;
  logic [TO_W-1:0] r_cnt, w_cnt_nxt;
  logic            r_last, w_last_nxt;   // 0 = I was granted last, 1 = D

  logic w_gnt_i, w_gnt_d, w_granted;
  logic w_cyc_x, w_stb_x, w_pending, w_fire, w_release;

  assign w_gnt_i   = (r_state == GNT_I);
  assign w_gnt_d   = (r_state == GNT_D);
  assign w_granted = w_gnt_i | w_gnt_d;
  assign w_cyc_x   = (w_gnt_i & iwbs_cyc_i) | (w_gnt_d & dwbs_cyc_i);
  assign w_stb_x   = (w_gnt_i & iwbs_stb_i) | (w_gnt_d & dwbs_stb_i);
  assign w_pending = w_cyc_x & w_stb_x & ~wbm_ack_i & ~wbm_err_i & ~r_abort;
  assign w_fire    = (TIMEOUT != 0) && w_pending && (r_cnt == TO_LAST);
  assign w_release = w_granted & ~w_cyc_x;

  always_comb begin
    w_next     = r_state;
    w_last_nxt = r_last;
    case (r_state)
      IDLE: begin
        if (iwbs_cyc_i && dwbs_cyc_i)
          w_next = (!ROUND_ROBIN || !r_last) ? GNT_D : GNT_I;
        else if (dwbs_cyc_i)
          w_next = GNT_D;
        else if (iwbs_cyc_i)
          w_next = GNT_I;
      end
      GNT_I: begin
        if (!iwbs_cyc_i) begin
          w_last_nxt = 1'b0;
          w_next     = dwbs_cyc_i ? GNT_D : IDLE;
        end
      end
      GNT_D: begin
        if (!dwbs_cyc_i) begin
          w_last_nxt = 1'b1;
          w_next     = iwbs_cyc_i ? GNT_I : IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Counter restarts whenever a new grant is entered, including a direct I<->D handover
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (TIMEOUT == 0)
      w_cnt_nxt = '0;
    else if ((w_next != r_state) && (w_next != IDLE))
      w_cnt_nxt = '0;
    else if (w_granted && (wbm_ack_i || wbm_err_i))
      w_cnt_nxt = '0;
    else if (w_pending)
      w_cnt_nxt = r_cnt + TO_W'(1);
  end

  always_comb begin
    w_abort_nxt = r_abort;
    if (w_release)
      w_abort_nxt = 1'b0;
    else if (w_fire)
      w_abort_nxt = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_abort <= 1'b0;
      r_cnt   <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_abort <= w_abort_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // After a watchdog abort the slave is cut off and any late response is swallowed
  assign wbm_cyc_o  = w_cyc_x & ~r_abort;
  assign wbm_stb_o  = w_stb_x & ~r_abort;
  assign wbm_we_o   = w_gnt_d & dwbs_we_i;
  assign wbm_sel_o  = w_gnt_d ? dwbs_sel_i : (w_gnt_i ? 4'hF : 4'h0);
  assign wbm_addr_o = w_gnt_d ? dwbs_addr_i : (w_gnt_i ? iwbs_addr_i : 32'h0);
  assign wbm_dat_o  = w_gnt_d ? dwbs_dat_i : 32'h0;

  assign iwbs_ack_o = w_gnt_i & ~r_abort & wbm_ack_i;
  assign iwbs_err_o = w_gnt_i & ((~r_abort & wbm_err_i) | w_fire);
  assign dwbs_ack_o = w_gnt_d & ~r_abort & wbm_ack_i;
  assign dwbs_err_o = w_gnt_d & ((~r_abort & wbm_err_i) | w_fire);
  assign iwbs_dat_o = w_granted ? wbm_dat_i : 32'h0;
  assign dwbs_dat_o = w_granted ? wbm_dat_i : 32'h0;

  assign grant_o   = {w_gnt_d, w_gnt_i};
  assign timeout_o = w_fire;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: fixed-priority and round-robin instances share stimulus; a cycle model
// built from the arbitration rules checks every output each cycle, plus directed table and sequences.
module tb_wb_bus_arbiter;
  localparam int TMO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, icyc, istb, dcyc, dstb, dwe, ack_r, err, auto_ack;
  logic [3:0]  dsel;
  logic [31:0] iaddr, daddr, ddat, rdat;
  logic        ack;

  logic        iack [2], ierr [2], dack [2], derr [2];
  logic        mcyc [2], mstb [2], mwe [2], tmo [2];
  logic [3:0]  msel [2];
  logic [1:0]  grant_w [2];
  logic [31:0] idat [2], ddat_o [2], maddr [2], mdat [2];

  assign ack = auto_ack ? mstb[1] : ack_r;

  wb_bus_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT(TMO), .TO_W(8)) u_fp (
    .clk_i(clk), .rst_i(rst_n),
    .iwbs_cyc_i(icyc), .iwbs_stb_i(istb), .iwbs_addr_i(iaddr),
    .iwbs_ack_o(iack[0]), .iwbs_err_o(ierr[0]), .iwbs_dat_o(idat[0]),
    .dwbs_cyc_i(dcyc), .dwbs_stb_i(dstb), .dwbs_we_i(dwe), .dwbs_sel_i(dsel),
    .dwbs_addr_i(daddr), .dwbs_dat_i(ddat),
    .dwbs_ack_o(dack[0]), .dwbs_err_o(derr[0]), .dwbs_dat_o(ddat_o[0]),
    .wbm_cyc_o(mcyc[0]), .wbm_stb_o(mstb[0]), .wbm_we_o(mwe[0]), .wbm_sel_o(msel[0]),
    .wbm_addr_o(maddr[0]), .wbm_dat_o(mdat[0]),
    .wbm_ack_i(ack), .wbm_err_i(err), .wbm_dat_i(rdat),
    .grant_o(grant_w[0]), .timeout_o(tmo[0])
  );

  wb_bus_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT(TMO), .TO_W(8)) u_rr (
    .clk_i(clk), .rst_i(rst_n),
    .iwbs_cyc_i(icyc), .iwbs_stb_i(istb), .iwbs_addr_i(iaddr),
    .iwbs_ack_o(iack[1]), .iwbs_err_o(ierr[1]), .iwbs_dat_o(idat[1]),
    .dwbs_cyc_i(dcyc), .dwbs_stb_i(dstb), .dwbs_we_i(dwe), .dwbs_sel_i(dsel),
    .dwbs_addr_i(daddr), .dwbs_dat_i(ddat),
    .dwbs_ack_o(dack[1]), .dwbs_err_o(derr[1]), .dwbs_dat_o(ddat_o[1]),
    .wbm_cyc_o(mcyc[1]), .wbm_stb_o(mstb[1]), .wbm_we_o(mwe[1]), .wbm_sel_o(msel[1]),
    .wbm_addr_o(maddr[1]), .wbm_dat_o(mdat[1]),
    .wbm_ack_i(ack), .wbm_err_i(err), .wbm_dat_i(rdat),
    .grant_o(grant_w[1]), .timeout_o(tmo[1])
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: owner 0 = nobody, 1 = I, 2 = D; wait counts stalled strobe cycles
  int m_own [2];
  int m_last [2];
  int m_wait [2];
  bit m_ab [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_own[k] = 0; m_last[k] = 1; m_wait[k] = 0; m_ab[k] = 1'b0;
    end
  endtask

  function automatic logic [141:0] model_out(int k);
    bit gi, gd, cx, sx, ab, fire;
    gi = (m_own[k] == 1);
    gd = (m_own[k] == 2);
    ab = m_ab[k];
    cx = gi ? icyc : (gd ? dcyc : 1'b0);
    sx = gi ? istb : (gd ? dstb : 1'b0);
    fire = (gi || gd) && cx && sx && !ack && !err && !ab && (m_wait[k] == TMO - 1);
    return {gd, gi, 1'(cx && !ab), 1'(sx && !ab), 1'(gd && dwe),
            gi ? 4'hF : (gd ? dsel : 4'h0),
            gi ? iaddr : (gd ? daddr : 32'h0),
            gd ? ddat : 32'h0,
            1'(gi && !ab && ack), 1'(gi && ((!ab && err) || fire)),
            (gi || gd) ? rdat : 32'h0,
            1'(gd && !ab && ack), 1'(gd && ((!ab && err) || fire)),
            (gi || gd) ? rdat : 32'h0,
            fire};
  endfunction

  function automatic logic [141:0] actual(int k);
    return {grant_w[k], mcyc[k], mstb[k], mwe[k], msel[k], maddr[k], mdat[k],
            iack[k], ierr[k], idat[k], dack[k], derr[k], ddat_o[k], tmo[k]};
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_own[k] = 0; m_last[k] = 1; m_wait[k] = 0; m_ab[k] = 1'b0;
      end else if (m_own[k] == 0) begin
        if (icyc && dcyc)      m_own[k] = (k == 1 && m_last[k] == 2) ? 1 : 2;
        else if (dcyc)         m_own[k] = 2;
        else if (icyc)         m_own[k] = 1;
        m_wait[k] = 0; m_ab[k] = 1'b0;
      end else begin
        bit cx, sx, fire, req;
        int other;
        cx = (m_own[k] == 1) ? icyc : dcyc;
        sx = (m_own[k] == 1) ? istb : dstb;
        if (!cx) begin
          m_last[k] = m_own[k];
          other = 3 - m_own[k];
          req = (other == 1) ? icyc : dcyc;
          m_own[k] = req ? other : 0;
          m_wait[k] = 0; m_ab[k] = 1'b0;
        end else begin
          fire = sx && !ack && !err && !m_ab[k] && (m_wait[k] == TMO - 1);
          if (ack || err)         m_wait[k] = 0;
          else if (sx && !m_ab[k]) m_wait[k] = m_wait[k] + 1;
          if (fire) m_ab[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [141:0] act, input logic [141:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick_a();
    @(negedge clk);
    chk("model_fp", actual(0), model_out(0));
    chk("model_rr", actual(1), model_out(1));
  endtask

  task automatic tick_b();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic tick();
    tick_a();
    tick_b();
  endtask

  typedef struct {
    logic icyc, istb, dcyc, dstb, dwe, ack;
    logic [31:0] daddr, ddat, rdat;
    logic [1:0]  e_grant;
    logic        e_cyc;
    logic [31:0] e_addr, e_idat;
    logic        e_iack, e_dack, e_derr, e_to;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input logic [5:0] in, input logic [31:0] da, dd, rd, input logic [1:0] g,
                     input logic c, input logic [31:0] ea, ei, input logic [3:0] e);
    vec_t v;
    {v.icyc, v.istb, v.dcyc, v.dstb, v.dwe, v.ack} = in;
    v.daddr = da; v.ddat = dd; v.rdat = rd;
    v.e_grant = g; v.e_cyc = c; v.e_addr = ea; v.e_idat = ei;
    {v.e_iack, v.e_dack, v.e_derr, v.e_to} = e;
    tbl.push_back(v);
  endtask

  logic [1:0] gseq [$];
  logic [1:0] g, gprev;
  logic       i_seen, d_seen;

  initial begin
    // inputs: {icyc,istb,dcyc,dstb,dwe,ack}; expect: {iack,dack,derr,timeout}
    add(6'b000000, 32'h0,   32'h0,        32'h0,  2'b00, 0, 32'h0,         32'h0,  4'b0000);
    add(6'b110000, 32'h0,   32'h0,        32'h0,  2'b00, 0, 32'h0,         32'h0,  4'b0000);
    add(6'b110000, 32'h0,   32'h0,        32'h0,  2'b01, 1, 32'h8000_0000, 32'h0,  4'b0000);
    add(6'b110001, 32'h0,   32'h0,        32'h13, 2'b01, 1, 32'h8000_0000, 32'h13, 4'b1000);
    add(6'b000000, 32'h0,   32'h0,        32'h0,  2'b01, 0, 32'h8000_0000, 32'h0,  4'b0000);
    add(6'b000000, 32'h0,   32'h0,        32'h0,  2'b00, 0, 32'h0,         32'h0,  4'b0000);
    add(6'b111110, 32'h100, 32'hDEADBEEF, 32'h0,  2'b00, 0, 32'h0,         32'h0,  4'b0000);
    add(6'b111110, 32'h100, 32'hDEADBEEF, 32'h0,  2'b10, 1, 32'h100,       32'h0,  4'b0000);
    add(6'b111111, 32'h100, 32'hDEADBEEF, 32'h0,  2'b10, 1, 32'h100,       32'h0,  4'b0100);
    add(6'b110000, 32'h100, 32'hDEADBEEF, 32'h0,  2'b10, 0, 32'h100,       32'h0,  4'b0000);
    add(6'b110000, 32'h100, 32'h0,        32'h0,  2'b01, 1, 32'h8000_0000, 32'h0,  4'b0000);
    add(6'b000000, 32'h100, 32'h0,        32'h0,  2'b01, 0, 32'h8000_0000, 32'h0,  4'b0000);
    add(6'b001100, 32'h200, 32'h0,        32'h0,  2'b00, 0, 32'h0,         32'h0,  4'b0000);
    add(6'b001100, 32'h200, 32'h0,        32'h0,  2'b10, 1, 32'h200,       32'h0,  4'b0000);
    add(6'b001100, 32'h200, 32'h0,        32'h0,  2'b10, 1, 32'h200,       32'h0,  4'b0000);
    add(6'b001100, 32'h200, 32'h0,        32'h0,  2'b10, 1, 32'h200,       32'h0,  4'b0000);
    add(6'b001100, 32'h200, 32'h0,        32'h0,  2'b10, 1, 32'h200,       32'h0,  4'b0011);
    add(6'b001100, 32'h200, 32'h0,        32'h0,  2'b10, 0, 32'h200,       32'h0,  4'b0000);
    add(6'b001101, 32'h200, 32'h0,        32'h55, 2'b10, 0, 32'h200,       32'h55, 4'b0000);
    add(6'b000000, 32'h200, 32'h0,        32'h0,  2'b10, 0, 32'h200,       32'h0,  4'b0000);
    add(6'b000000, 32'h200, 32'h0,        32'h0,  2'b00, 0, 32'h0,         32'h0,  4'b0000);
    add(6'b110000, 32'h200, 32'h0,        32'h0,  2'b00, 0, 32'h0,         32'h0,  4'b0000);
    add(6'b111100, 32'h200, 32'h0,        32'h0,  2'b01, 1, 32'h8000_0000, 32'h0,  4'b0000);
    add(6'b111101, 32'h200, 32'h0,        32'hA1, 2'b01, 1, 32'h8000_0000, 32'hA1, 4'b1000);
    add(6'b101100, 32'h200, 32'h0,        32'h0,  2'b01, 1, 32'h8000_0000, 32'h0,  4'b0000);
    add(6'b111101, 32'h200, 32'h0,        32'hA2, 2'b01, 1, 32'h8000_0000, 32'hA2, 4'b1000);
    add(6'b101100, 32'h200, 32'h0,        32'h0,  2'b01, 1, 32'h8000_0000, 32'h0,  4'b0000);
    add(6'b111101, 32'h200, 32'h0,        32'hA3, 2'b01, 1, 32'h8000_0000, 32'hA3, 4'b1000);
    add(6'b001100, 32'h200, 32'h0,        32'h0,  2'b01, 0, 32'h8000_0000, 32'h0,  4'b0000);
    add(6'b001100, 32'h200, 32'h0,        32'h0,  2'b10, 1, 32'h200,       32'h0,  4'b0000);
    add(6'b000000, 32'h200, 32'h0,        32'h0,  2'b10, 0, 32'h200,       32'h0,  4'b0000);
    add(6'b000000, 32'h200, 32'h0,        32'h0,  2'b00, 0, 32'h0,         32'h0,  4'b0000);

    rst_n = 1'b0; auto_ack = 1'b0;
    {icyc, istb, dcyc, dstb, dwe, ack_r, err} = '0;
    dsel = 4'hF; iaddr = 32'h8000_0000; daddr = '0; ddat = '0; rdat = '0;
    model_reset();
    tick_b();
    tick_a();
    chk("reset_fp", actual(0), '0);
    chk("reset_rr", actual(1), '0);
    tick_b();
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      {icyc, istb, dcyc, dstb, dwe, ack_r} =
        {tbl[i].icyc, tbl[i].istb, tbl[i].dcyc, tbl[i].dstb, tbl[i].dwe, tbl[i].ack};
      daddr = tbl[i].daddr; ddat = tbl[i].ddat; rdat = tbl[i].rdat;
      tick_a();
      chk($sformatf("tbl[%0d]", i),
          {grant_w[0], mcyc[0], maddr[0], idat[0], iack[0], dack[0], derr[0], tmo[0]},
          {tbl[i].e_grant, tbl[i].e_cyc, tbl[i].e_addr, tbl[i].e_idat,
           tbl[i].e_iack, tbl[i].e_dack, tbl[i].e_derr, tbl[i].e_to});
      tick_b();
    end

    // Asynchronous reset while D has a strobe outstanding
    dcyc = 1'b1; dstb = 1'b1; dwe = 1'b0; daddr = 32'h300; ack_r = 1'b0;
    tick();
    tick_a();
    rst_n = 1'b0;
    model_reset();
    ack_r = 1'b1;
    #1;
    for (int k = 0; k < 2; k++)
      chk("rst_async", {grant_w[k], mcyc[k], iack[k], dack[k], ierr[k], derr[k]}, '0);
    tick_b();
    rst_n = 1'b1; dcyc = 1'b0; dstb = 1'b0; icyc = 1'b1; istb = 1'b1; ack_r = 1'b0;
    tick_a();
    chk("rst_release_idle", grant_w[0], 2'b00);
    tick_b();
    tick_a();
    chk("rst_then_gnt_i", grant_w[0], 2'b01);
    tick_b();
    icyc = 1'b0; istb = 1'b0;
    tick();

    // Round robin: fresh reset, both masters issue back-to-back single transfers
    rst_n = 1'b0; model_reset();
    tick();
    rst_n = 1'b1;
    auto_ack = 1'b1;
    icyc = 1'b1; istb = 1'b1; dcyc = 1'b1; dstb = 1'b1;
    gprev = 2'b00;
    for (int c = 0; c < 14; c++) begin
      tick_a();
      g = grant_w[1];
      if (g != 2'b00 && g != gprev) gseq.push_back(g);
      if (g != 2'b00) gprev = g;
      chk("rr_ack_route", {iack[1], dack[1]}, {1'(m_own[1] == 1 && ack), 1'(m_own[1] == 2 && ack)});
      i_seen = iack[1]; d_seen = dack[1];
      tick_b();
      icyc = !i_seen; istb = icyc;
      dcyc = !d_seen; dstb = dcyc;
    end
    for (int j = 0; j < 4; j++)
      chk($sformatf("rr_grant_seq[%0d]", j), (j < gseq.size()) ? gseq[j] : 2'b00,
          (j % 2 == 0) ? 2'b10 : 2'b01);
    auto_ack = 1'b0;
    {icyc, istb, dcyc, dstb} = '0;
    tick();
    tick();

    // Randomized traffic against the model, with occasional asynchronous resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7) == 0) icyc = ~icyc;
      if ($urandom_range(7) == 0) dcyc = ~dcyc;
      istb  = 1'($urandom_range(1));
      dstb  = 1'($urandom_range(1));
      dwe   = 1'($urandom_range(1));
      dsel  = 4'($urandom_range(15));
      ack_r = ($urandom_range(3) == 0);
      err   = ($urandom_range(15) == 0);
      iaddr = $urandom; daddr = $urandom; ddat = $urandom; rdat = $urandom;
      if ($urandom_range(299) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else begin
        rst_n = 1'b1;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
